// File: rtl/instr_encoder_pkg.sv
// Encoder package: field widths, request payload struct, format select,
// opcode legality and word packing helpers shared by the encoder files.
`include "instr_encoder_defs.sv"

package instr_encoder_pkg;

  localparam int unsigned IW   = `IWIDTH;
  localparam int unsigned OPW  = `OPCODE_WIDTH;
  localparam int unsigned FNW  = `FUNCT_WIDTH;
  localparam int unsigned AW   = `AWIDTH;
  localparam int unsigned IMMW = `IMM_WIDTH;
  localparam int unsigned SHW  = 5;
  localparam int unsigned TGTW = 26;
  localparam int unsigned ECW  = 8;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_e;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [FNW-1:0]  funct;
    logic [AW-1:0]   rs;
    logic [AW-1:0]   rt;
    logic [AW-1:0]   rd;
    logic [SHW-1:0]  shamt;
    logic [IMMW-1:0] imm;
    logic [TGTW-1:0] target;
  } enc_req_t;

  // Instruction format implied by the opcode.
  function automatic fmt_e fmt_of(input logic [OPW-1:0] op);
    if (op == `OP_RTYPE) begin
      return FMT_R;
    end else if (op == `OP_J || op == `OP_JAL) begin
      return FMT_J;
    end else begin
      return FMT_I;
    end
  endfunction

  // True only for opcodes present in the shared define list.
  function automatic logic is_legal(input logic [OPW-1:0] op);
    case (op)
      `OP_RTYPE, `OP_LW, `OP_SW, `OP_BEQ,
      `OP_ADDI, `OP_BNE, `OP_J, `OP_JAL: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Pack a request into its 32-bit word; fields outside the format are dropped.
  function automatic logic [IW-1:0] pack_word(input enc_req_t req);
    case (fmt_of(req.opcode))
      FMT_R:   return {req.opcode, req.rs, req.rt, req.rd, req.shamt, req.funct};
      FMT_J:   return {req.opcode, req.target};
      default: return {req.opcode, req.rs, req.rt, req.imm};
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Encoder bus: field request channel (e_i_valid/e_o_ready + fields) and
// word output channel (e_o_valid/e_i_ready, e_o_instr, e_o_addr) plus error status.
// master = request producer / word consumer, slave = encoder.
interface instr_encoder_if
  import instr_encoder_pkg::*;
#(
  parameter int unsigned MAW = 32
);

  logic            e_i_valid;
  logic            e_o_ready;
  logic [OPW-1:0]  e_i_opcode;
  logic [FNW-1:0]  e_i_funct;
  logic [AW-1:0]   e_i_addr_rs;
  logic [AW-1:0]   e_i_addr_rt;
  logic [AW-1:0]   e_i_addr_rd;
  logic [SHW-1:0]  e_i_shamt;
  logic [IMMW-1:0] e_i_imm;
  logic [TGTW-1:0] e_i_target;
  logic            e_o_valid;
  logic            e_i_ready;
  logic [IW-1:0]   e_o_instr;
  logic [MAW-1:0]  e_o_addr;
  logic            e_o_err;
  logic [ECW-1:0]  e_o_err_cnt;

  modport master (
    output e_i_valid, e_i_opcode, e_i_funct, e_i_addr_rs, e_i_addr_rt,
           e_i_addr_rd, e_i_shamt, e_i_imm, e_i_target, e_i_ready,
    input  e_o_ready, e_o_valid, e_o_instr, e_o_addr, e_o_err, e_o_err_cnt
  );

  modport slave (
    input  e_i_valid, e_i_opcode, e_i_funct, e_i_addr_rs, e_i_addr_rt,
           e_i_addr_rd, e_i_shamt, e_i_imm, e_i_target, e_i_ready,
    output e_o_ready, e_o_valid, e_o_instr, e_o_addr, e_o_err, e_o_err_cnt
  );

endinterface

// File: rtl/enc_fifo2.sv
// Two-entry FIFO for encoded words.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop, full, empty, head.
// Push is ignored when full and pop when empty; head is the oldest entry.
module enc_fifo2
  import instr_encoder_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [IW-1:0] wdata,
  output logic          full,
  output logic          empty,
  output logic [IW-1:0] head
);

  logic [IW-1:0] mem_q [0:1];
  logic          wr_q;
  logic          rd_q;
  logic [1:0]    cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem_q[rd_q];

  // Storage, pointers and occupancy; reset clears storage so head reads zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= ~wr_q;
      end
      if (pop_ok) begin
        rd_q <= ~rd_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_defs.sv
// Shared ISA definitions for the encoder and the decode stage.
// Holds word/field widths, every legal opcode (OP_*) and the R-type funct codes (FN_*).
// Include guard allows several files in one compilation unit to include it.
`ifndef INSTR_ENCODER_DEFS_SV
`define INSTR_ENCODER_DEFS_SV

`define IWIDTH        32
`define DWIDTH        32
`define AWIDTH        5
`define OPCODE_WIDTH  6
`define FUNCT_WIDTH   6
`define IMM_WIDTH     16

`define OP_RTYPE      6'h00
`define OP_LW         6'h01
`define OP_SW         6'h02
`define OP_BEQ        6'h03
`define OP_ADDI       6'h04
`define OP_BNE        6'h05
`define OP_J          6'h06
`define OP_JAL        6'h07

`define FN_SLL        6'h00
`define FN_SRL        6'h02
`define FN_ADD        6'h20
`define FN_SUB        6'h22
`define FN_AND        6'h24
`define FN_OR         6'h25
`define FN_SLT        6'h2A

`endif

// File: rtl/instr_encoder.sv
// Field-level instruction encoder: packs requests into 32-bit words and streams
// them with sequential instruction-memory addresses through a 2-entry buffer.
// Ports: e_clk, e_rst (sync, active-low), bus (instr_encoder_if.slave):
//   request side e_i_valid/e_o_ready + fields, output side e_o_valid/e_i_ready,
//   e_o_instr, e_o_addr, error pulse e_o_err and saturating e_o_err_cnt.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAW       = 32
) (
  input  logic           e_clk,
  input  logic           e_rst,
  instr_encoder_if.slave bus
);

  enc_req_t       req_c;
  logic [IW-1:0]  word_c;
  logic [IW-1:0]  head_c;
  logic           legal_c;
  logic           accept_c;
  logic           push_c;
  logic           pop_c;
  logic           bad_c;
  logic           full_c;
  logic           empty_c;

  logic           run_q;
  logic           err_q;
  logic [ECW-1:0] err_cnt_q;
  logic [MAW-1:0] addr_q;

  // Gather the request fields into one payload.
  always_comb begin
    req_c        = '0;
    req_c.opcode = bus.e_i_opcode;
    req_c.funct  = bus.e_i_funct;
    req_c.rs     = bus.e_i_addr_rs;
    req_c.rt     = bus.e_i_addr_rt;
    req_c.rd     = bus.e_i_addr_rd;
    req_c.shamt  = bus.e_i_shamt;
    req_c.imm    = bus.e_i_imm;
    req_c.target = bus.e_i_target;
  end

  assign word_c   = pack_word(req_c);
  assign legal_c  = is_legal(req_c.opcode);
  assign accept_c = bus.e_i_valid & bus.e_o_ready;
  assign push_c   = accept_c & legal_c;
  // Illegal requests are consumed like any other, so they never stall.
  assign bad_c    = accept_c & ~legal_c;
  assign pop_c    = bus.e_o_valid & bus.e_i_ready;

  enc_fifo2 u_fifo (
    .clk   (e_clk),
    .rst_n (e_rst),
    .push  (push_c),
    .pop   (pop_c),
    .wdata (word_c),
    .full  (full_c),
    .empty (empty_c),
    .head  (head_c)
  );

  // run_q holds ready low while in reset; address tracks the FIFO head.
  always_ff @(posedge e_clk) begin
    if (!e_rst) begin
      run_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      addr_q    <= MAW'(BASE_ADDR);
    end else begin
      run_q <= 1'b1;
      err_q <= bad_c;
      if (bad_c && err_cnt_q != {ECW{1'b1}}) begin
        err_cnt_q <= err_cnt_q + ECW'(1);
      end
      if (pop_c) begin
        addr_q <= addr_q + MAW'(4);
      end
    end
  end

  assign bus.e_o_ready   = run_q & ~full_c;
  assign bus.e_o_valid   = ~empty_c;
  assign bus.e_o_instr   = head_c;
  assign bus.e_o_addr    = addr_q;
  assign bus.e_o_err     = err_q;
  assign bus.e_o_err_cnt = err_cnt_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

- Packs field-level instruction requests (opcode, funct, rs, rt, rd, shamt, imm, target) into 32-bit MIPS words.
- Streams the words, each with a sequential instruction-memory address, to the instruction-memory loader and test harnesses.
- It is the inverse of the decode stage: each emitted word, when decoded, must reproduce the accepted fields.
- Valid/ready on both sides, with a 2-entry output buffer.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: address assigned to the first emitted word.
- MAW, 32: width of the emitted memory address.

Ports:
- e_clk  in  1  clock; all logic on rising edge.
- e_rst  in  1  reset, synchronous, active-low.
- e_i_valid  in  1  field request valid.
- e_o_ready  out  1  encoder can accept a request.
- e_i_opcode  in  `OPCODE_WIDTH  opcode.
- e_i_funct  in  `FUNCT_WIDTH  funct (R-type only).
- e_i_addr_rs, e_i_addr_rt, e_i_addr_rd  in  `AWIDTH  register fields.
- e_i_shamt  in  5  shift amount (R-type only).
- e_i_imm  in  `IMM_WIDTH  immediate (I-type only).
- e_i_target  in  26  jump target (J-type only).
- e_o_valid  out  1  encoded word available.
- e_i_ready  in  1  consumer takes the word.
- e_o_instr  out  `IWIDTH  encoded word.
- e_o_addr  out  MAW  address of e_o_instr.
- e_o_err  out  1  one-cycle pulse: request rejected (illegal opcode).
- e_o_err_cnt  out  8  saturating count of rejected requests.

## Operation
Format selection by opcode, using the shared defines:
- R-type: opcode == `OP_RTYPE. Word = {opcode, rs, rt, rd, shamt, funct}.
- J-type: opcode is `OP_J or `OP_JAL. Word = {opcode, target}.
- I-type: any other legal opcode (`OP_ADDI, `OP_BEQ, `OP_LW, `OP_SW, ...). Word = {opcode, rs, rt, imm}.

Request handling:
- Fields unused by the selected format are ignored.
- Illegal opcode (not in the define list):
  - The request is consumed and not enqueued.
  - e_o_err pulses one cycle later.
  - e_o_err_cnt increments and saturates at 255.
- Accept = e_i_valid & e_o_ready. The encoded word is written into the 2-entry FIFO.

Address counter:
- Starts at BASE_ADDR.
- Increments by 4 on every output handshake (e_o_valid & e_i_ready).
- Wraps modulo 2^MAW with no flag.
- e_o_addr always shows the address of the current FIFO head.

Flow control:
- e_o_ready = FIFO not full, driven from a registered count.
- Push and pop in the same cycle: count unchanged, order preserved.
- When the FIFO is full, e_o_ready is low and no push occurs even if a pop happens that cycle.

## Timing
- Latency: request accepted at edge N appears on e_o_instr/e_o_valid after edge N; usable by the consumer at edge N+1.
- Back-to-back requests are sustained at 1 word/cycle while e_i_ready = 1.
- Reset, on any edge with e_rst = 0:
  - FIFO emptied; e_o_valid = 0; e_o_ready = 0 during reset, 1 on the first cycle after.
  - e_o_instr = 0 and e_o_addr = BASE_ADDR.
  - e_o_err = 0 and e_o_err_cnt = 0.
- Reset mid-stream discards buffered words; addresses restart at BASE_ADDR.
- e_o_instr and e_o_addr stay stable while e_o_valid = 1 and e_i_ready = 0.
- An illegal request never stalls: it is accepted whenever e_o_ready = 1.

## Structure
- Shared defines header, included by both encoder and decoder: IWIDTH, DWIDTH, AWIDTH, OPCODE_WIDTH, FUNCT_WIDTH, IMM_WIDTH, all OP_* opcodes and FN_* funct codes. The encoder adds no private opcode values.
- Sub-module enc_fifo2:
  - 2-entry FIFO, width IWIDTH.
  - Ports: push/pop, full/empty, head data.
- Top level contains:
  - combinational format select and pack;
  - legality check;
  - address counter;
  - error counter.

## Test plan
- R-type: opcode 0, rs=2, rt=3, rd=1, shamt=0, funct=0x20, e_i_ready=1 → e_o_instr=0x00430820, e_o_addr=0x0 one cycle after accept.
- I-type: `OP_ADDI (4), rs=2, rt=1, imm=100; then `OP_BEQ (3), rs=11, rt=11, imm=16, with rd/funct driven to junk → 0x10410064 at addr 0x0, then 0x0D6B0010 at addr 0x4.
- Backpressure:
  - Hold e_i_ready=0 and send 3 requests → e_o_ready drops after 2; head word and address stay stable.
  - Release → words emitted in order at addr 0x0, 0x4, 0x8.
- Illegal opcode 0x3F → no word emitted; e_o_err pulses once; e_o_err_cnt=1. 300 illegal requests → e_o_err_cnt saturates at 255.
- Reset with 2 words buffered → e_o_valid=0 next cycle; next accepted word is emitted at BASE_ADDR.
- MAW=4, BASE_ADDR=0xC → fourth emitted word is at address 0x8 (0xC, 0x0, 0x4, 0x8).
